// File: rtl/mem_access.sv
// Memory-access pipeline stage: serialises byte-wide RAM traffic for loads and stores,
// stalls the front of the pipe until the access completes, and extends load data.
module mem_access #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mm_wa,
  input  logic              mm_we,
  input  logic [31:0]       mm_wn,
  input  logic [4:0]        mm_mem_e,
  input  logic [31:0]       mm_mem_n,
  output logic [4:0]        wb_wa,
  output logic              wb_we,
  output logic [31:0]       wb_wn,
  output logic              stl_mm,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              ram_gnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [1:0]        cnt_reg;
  logic [1:0]        last_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              store_reg;
  logic [2:0]        f3_reg;
  logic [31:0]       sdata_reg;
  logic [31:0]       ldbuf_reg, ldbuf_next;
  logic              cap_pend_reg;
  logic [1:0]        cap_lane_reg;

  logic              start;
  logic              issue;
  logic              is_last;
  logic [7:0]        store_byte [4];
  logic [31:0]       load_ext;

  // Index of the final byte of the access: 1, 2 or 4 bytes wide.
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  assign start   = (state_reg == IDLE) && mm_mem_e[4];
  assign issue   = (state_reg == ACC) && ram_gnt;
  assign is_last = (cnt_reg == last_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (mm_mem_e[4]) state_next = ACC;
      ACC:   if (issue && is_last) state_next = store_reg ? DONE : FLUSH;
      FLUSH: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each lane of the load buffer takes ram_din one cycle after its byte was issued.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_byte[gi] = sdata_reg[8*gi +: 8];
      assign ldbuf_next[8*gi +: 8] = (cap_pend_reg && (cap_lane_reg == 2'(gi)))
                                     ? ram_din : ldbuf_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      last_reg     <= 2'd0;
      base_reg     <= '0;
      store_reg    <= 1'b0;
      f3_reg       <= 3'd0;
      sdata_reg    <= 32'd0;
      ldbuf_reg    <= 32'd0;
      cap_pend_reg <= 1'b0;
      cap_lane_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      cap_pend_reg <= issue && !store_reg;
      cap_lane_reg <= cnt_reg;
      if (start) begin
        base_reg  <= mm_wn[ADDR_W-1:0];
        last_reg  <= last_idx(mm_mem_e[1:0]);
        store_reg <= mm_mem_e[3];
        f3_reg    <= mm_mem_e[2:0];
        sdata_reg <= mm_mem_n;
        cnt_reg   <= 2'd0;
        ldbuf_reg <= 32'd0;
      end else begin
        if (issue) cnt_reg <= cnt_reg + 2'd1;
        ldbuf_reg <= ldbuf_next;
      end
    end
  end

  // RAM port is driven only while a granted byte is being issued; address wraps at 2^ADDR_W.
  assign ram_a    = issue ? (base_reg + ADDR_W'(cnt_reg)) : '0;
  assign ram_wr   = issue && store_reg;
  assign ram_dout = issue ? store_byte[cnt_reg] : 8'd0;

  always_comb begin
    load_ext = ldbuf_reg;
    case (f3_reg)
      3'b000:  load_ext = {{24{ldbuf_reg[7]}}, ldbuf_reg[7:0]};
      3'b001:  load_ext = {{16{ldbuf_reg[15]}}, ldbuf_reg[15:0]};
      3'b100:  load_ext = {24'd0, ldbuf_reg[7:0]};
      3'b101:  load_ext = {16'd0, ldbuf_reg[15:0]};
      default: load_ext = ldbuf_reg;
    endcase
  end

  assign stl_mm = mm_mem_e[4] && (state_reg != DONE);
  assign wb_wa  = mm_wa;
  assign wb_we  = mm_we & ~(mm_mem_e[4] & mm_mem_e[3]);
  assign wb_wn  = ((state_reg == DONE) && !store_reg) ? load_ext : mm_wn;

endmodule
